mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Multi-cycle multiply/divide unit with its own sequencer. It owns the HI/LO register pair and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO from the Execute stage. It raises a stall to the hazard unit whenever an Execute-stage instruction needs the unit while an operation is in flight. It sits beside the ALU in E and is driven by decode-stage control, pipelined into E by the controller.

## Interface
Parameters:
- MUL_LAT, 4: multiply latency in cycles when the fast-multiply option is compiled out; legal range 1–32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- mdstartE  input  1  Execute-stage mult/div instruction valid.
- mdopE  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- mthiE, mtloE  input  1 each  write srcaE into HI / LO.
- mfhiE, mfloE  input  1 each  read HI / LO onto hiloE.
- srcaE, srcbE  input  32 each  operands; dividend and multiplicand are srcaE.
- hiloE  output  32  read data; HI if mfhiE, else LO if mfloE, else 0.
- stallMD  output  1  combinational; freeze F/D/E (E holds its operands).
- busy  output  1  registered; operation in flight.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- Accept: any request is accepted only in a cycle where busy=0.
- Request priority if several requests are asserted: mdstart > mthi/mtlo > mfhi/mflo.
- stallMD = busy & (mdstartE | mthiE | mtloE | mfhiE | mfloE).
- IDLE + mdstartE, MULT/MULTU (macro off):
  - Latch the operands.
  - Load the counter with MUL_LAT-1.
  - Go to MUL.
- MUL:
  - Decrement the counter.
  - At count 0, write the 64-bit product {HI,LO} and return to IDLE.
  - The product is signed for MULT and unsigned for MULTU.
- IDLE + DIV/DIVU:
  - Latch the magnitudes (abs for DIV) and record the quotient and remainder signs.
  - Clear the 32-bit partial remainder.
  - Load the counter with 31.
  - Go to DIV.
- DIV:
  - Radix-2 restoring division, one quotient bit per cycle, 32 cycles.
  - Then go to FIX.
- FIX:
  - Negate the quotient if the operand signs differ (DIV only).
  - Give the remainder the sign of the dividend.
  - Write LO=quotient and HI=remainder, then return to IDLE.
- Divide by zero (srcbE=0): LO=32'hFFFFFFFF, HI=srcaE, same latency as a normal divide, no exception.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- mthiE/mtloE when idle: HI or LO is written at the end of the same cycle.
- mfhi/mflo when idle: hiloE reflects the current register contents combinationally. A read in the cycle after a completion sees the new result.
- Reset:
  - HI=LO=0, busy=0, state IDLE.
  - Asserting reset mid-operation discards the operation; HI/LO are cleared.
  - With no requests, stallMD=0 and hiloE=0.

## Timing
- An accepted op in cycle T makes busy=1 from T+1.
- MUL: busy for MUL_LAT cycles; HI/LO are updated at the edge ending T+MUL_LAT; busy=0 in T+MUL_LAT+1.
- DIV: 32 DIV cycles plus 1 FIX cycle; HI/LO are updated at the edge ending T+33; busy=0 at T+34.
- Back-to-back: a new mdstartE in the first cycle with busy=0 is accepted without a bubble.
- A request arriving while busy stalls until the first cycle with busy=0, and is serviced in that cycle.
- stallMD has no registered delay; it must meet E-stage timing to the hazard unit.

## Configuration
- MDU_FAST_MUL_EN defined:
  - Multiply completes in 1 cycle: product registered at the end of T, busy never asserted for MULT/MULTU, MUL state unused.
  - MUL_LAT is ignored.
- MDU_FAST_MUL_EN undefined: multiply takes MUL_LAT cycles as above. Division timing is identical in both builds.

## Test plan
- MULTU FFFFFFFF×FFFFFFFF, then mfhi/mflo after completion -> HI=FFFFFFFE, LO=00000001. Repeat as MULT -> HI=0, LO=1.
- DIV -7/2 -> LO=FFFFFFFD, HI=FFFFFFFF. DIVU 100/7 -> LO=0000000E, HI=00000002. HI/LO are unchanged until cycle T+34.
- DIV 1234/0 -> LO=FFFFFFFF, HI=000004D2. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- mflo issued at T+1 after a DIV accepted at T -> stallMD=1 for exactly 33 cycles, then hiloE=quotient with stallMD=0.
- mthi AAAA5555 while idle, mfhi next cycle -> hiloE=AAAA5555. mthi while busy -> stalled, HI keeps the division result ordering.
- Reset at T+10 of a DIV -> next cycle busy=0, HI=LO=0, stallMD=0. A new MULT is accepted immediately.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit owning HI/LO, with its own sequencer and E-stage stall.
// Define MDU_FAST_MUL_EN for a single-cycle multiply; otherwise multiply takes MUL_LAT cycles.
module mdu_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdstartE,
  input  logic [1:0]  mdopE,
  input  logic        mthiE,
  input  logic        mtloE,
  input  logic        mfhiE,
  input  logic        mfloE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  output logic [31:0] hiloE,
  output logic        stallMD,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;
  localparam logic [1:0] FIX  = 2'd3;
`ifndef MDU_FAST_MUL_EN
  localparam logic [4:0] MUL_CNT = 5'(MUL_LAT - 1);
`endif

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] hi, lo;
  logic [31:0] opA, opB, rem;   // opA is the dividend/quotient shift register during DIV
  logic        opSigned, qNeg, rNeg;

  logic        inSigned;
  logic [31:0] absA, absB;
  logic [32:0] shifted, trial;
  logic        trialOk;
  logic [31:0] quotOut, remOut;

  function automatic logic [63:0] fullProduct(input logic [31:0] a, input logic [31:0] b,
                                              input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  assign inSigned = ~mdopE[0];
  assign absA     = (inSigned && srcaE[31]) ? -srcaE : srcaE;
  assign absB     = (inSigned && srcbE[31]) ? -srcbE : srcbE;

  // Restoring step: shift in the next dividend bit, keep the subtraction only if it did not borrow.
  assign shifted  = {rem, opA[31]};
  assign trial    = shifted - {1'b0, opB};
  assign trialOk  = ~trial[32];

  assign quotOut  = qNeg ? -opA : opA;
  assign remOut   = rNeg ? -rem : rem;

  assign stallMD  = busy & (mdstartE | mthiE | mtloE | mfhiE | mfloE);
  assign hiloE    = mfhiE ? hi : (mfloE ? lo : 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mdstartE) begin
            if (mdopE[1]) begin
              state <= DIV;
              busy  <= 1'b1;
              count <= 5'd31;
            end else begin
`ifdef MDU_FAST_MUL_EN
              {hi, lo} <= fullProduct(srcaE, srcbE, inSigned);
`else
              state <= MUL;
              busy  <= 1'b1;
              count <= MUL_CNT;
`endif
            end
          end else begin
            if (mthiE) hi <= srcaE;
            if (mtloE) lo <= srcaE;
          end
        end
        MUL: begin
          if (count == 5'd0) begin
            {hi, lo} <= fullProduct(opA, opB, opSigned);
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            count <= count - 5'd1;
          end
        end
        DIV: begin
          if (count == 5'd0) state <= FIX;
          else               count <= count - 5'd1;
        end
        FIX: begin
          lo    <= quotOut;
          hi    <= remOut;
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: operand/partial-remainder registers are not reset; they are always loaded on acceptance
  // before being read, so only the control state and the architectural HI/LO need a reset.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (mdstartE) begin
          opSigned <= inSigned;
          if (mdopE[1]) begin
            opA  <= absA;
            opB  <= absB;
            rem  <= 32'd0;
            // A zero divisor leaves the all-ones quotient unsigned and the remainder equal to srcaE.
            qNeg <= inSigned & (srcaE[31] ^ srcbE[31]) & (srcbE != 32'd0);
            rNeg <= inSigned & srcaE[31];
          end else begin
            opA <= srcaE;
            opB <= srcbE;
          end
        end
      end
      DIV: begin
        rem <= trialOk ? trial[31:0] : shifted[31:0];
        opA <= {opA[30:0], trialOk};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized instruction stream
// compared cycle by cycle against an arithmetic model of HI/LO and the busy window.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 4;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = MUL_LAT;
`endif
  localparam int DIV_CYC = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdstartE = 1'b0;
  logic [1:0]  mdopE = 2'b00;
  logic        mthiE = 1'b0, mtloE = 1'b0, mfhiE = 1'b0, mfloE = 1'b0;
  logic [31:0] srcaE = 32'd0, srcbE = 32'd0;
  logic [31:0] hiloE;
  logic        stallMD, busy;

  always #5 clk = ~clk;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .mdstartE(mdstartE), .mdopE(mdopE),
    .mthiE(mthiE), .mtloE(mtloE), .mfhiE(mfhiE), .mfloE(mfloE),
    .srcaE(srcaE), .srcbE(srcbE), .hiloE(hiloE), .stallMD(stallMD), .busy(busy)
  );

  int          nChecks = 0;
  int          nPass = 0;
  logic [31:0] mHi = 32'd0, mLo = 32'd0, pHi = 32'd0, pLo = 32'd0;
  int          busyLeft = 0;
  logic [31:0] lastHilo;
  logic        lastStall;
  int          stallCount;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference result {HI,LO} from plain integer arithmetic.
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    logic [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    q  = 32'd0;
    r  = 32'd0;
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = a;
        end else if (op == 2'b10) begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end else begin
          q = a / b;
          r = a % b;
        end
        return {r, q};
      end
    endcase
  endfunction

  task automatic modelEdge();
    if (reset) begin
      mHi = 32'd0; mLo = 32'd0; busyLeft = 0;
    end else if (busyLeft > 0) begin
      busyLeft--;
      if (busyLeft == 0) begin mHi = pHi; mLo = pLo; end
    end else if (mdstartE) begin
      {pHi, pLo} = refResult(mdopE, srcaE, srcbE);
      busyLeft = mdopE[1] ? DIV_CYC : MUL_CYC;
      if (busyLeft == 0) begin mHi = pHi; mLo = pLo; end
    end else begin
      if (mthiE) mHi = srcaE;
      if (mtloE) mLo = srcaE;
    end
  endtask

  task automatic step();
    logic anyReq;
    @(negedge clk);
    anyReq = mdstartE | mthiE | mtloE | mfhiE | mfloE;
    check("busy", busy, busyLeft > 0);
    check("stallMD", stallMD, (busyLeft > 0) && anyReq);
    check("hiloE", hiloE, mfhiE ? mHi : (mfloE ? mLo : 32'd0));
    lastHilo  = hiloE;
    lastStall = stallMD;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Present one instruction and hold it, as the stalled E stage would, until it is accepted.
  task automatic issue(input logic md, input logic thi, input logic tlo, input logic fhi,
                       input logic flo, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bit accepted;
    int guard;
    accepted = 1'b0;
    guard = 0;
    mdstartE = md; mthiE = thi; mtloE = tlo; mfhiE = fhi; mfloE = flo;
    mdopE = op; srcaE = a; srcbE = b;
    stallCount = 0;
    while (!accepted && guard < 200) begin
      accepted = (busyLeft == 0);
      step();
      if (lastStall) stallCount++;
      guard++;
    end
    if (!accepted) check("accept_timeout", 1'b0, 1'b1);
    mdstartE = 1'b0; mthiE = 1'b0; mtloE = 1'b0; mfhiE = 1'b0; mfloE = 1'b0;
    mdopE = 2'b00; srcaE = 32'd0; srcbE = 32'd0;
  endtask

  task automatic mdOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op, a, b);
  endtask

  task automatic readHi();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic readLo();
    issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'd0, 32'd0);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    modelEdge();
    #1;
    reset = 1'b0;

    // Reset state
    idle(1);
    readHi();
    check("rst_hi", lastHilo, 32'h0);
    readLo();
    check("rst_lo", lastHilo, 32'h0);

    // Multiply corners
    mdOp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    readHi();
    check("multu_hi", lastHilo, 32'hFFFF_FFFE);
    readLo();
    check("multu_lo", lastHilo, 32'h0000_0001);
    mdOp(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    readHi();
    check("mult_hi", lastHilo, 32'h0);
    readLo();
    check("mult_lo", lastHilo, 32'h1);

    // Signed divide with an mflo stalled from T+1
    mdOp(2'b10, 32'hFFFF_FFF9, 32'd2);
    readLo();
    check("div_stall_cycles", stallCount, DIV_CYC);
    check("div_lo", lastHilo, 32'hFFFF_FFFD);
    readHi();
    check("div_hi", lastHilo, 32'hFFFF_FFFF);

    mdOp(2'b11, 32'd100, 32'd7);
    readLo();
    check("divu_lo", lastHilo, 32'h0000_000E);
    readHi();
    check("divu_hi", lastHilo, 32'h0000_0002);

    mdOp(2'b10, 32'd1234, 32'd0);
    readLo();
    check("div0_lo", lastHilo, 32'hFFFF_FFFF);
    readHi();
    check("div0_hi", lastHilo, 32'h0000_04D2);

    mdOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    readLo();
    check("divovf_lo", lastHilo, 32'h8000_0000);
    readHi();
    check("divovf_hi", lastHilo, 32'h0);

    // Move-to while idle, then while busy
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'hAAAA_5555, 32'd0);
    readHi();
    check("mthi_idle", lastHilo, 32'hAAAA_5555);
    mdOp(2'b10, 32'd100, 32'd7);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h1234_5678, 32'd0);
    check("mthi_busy_stall", stallCount, DIV_CYC);
    readHi();
    check("mthi_after_div", lastHilo, 32'h1234_5678);
    readLo();
    check("div_lo_kept", lastHilo, 32'd14);

    // Back-to-back: a second op waits exactly for the first to finish
    mdOp(2'b11, 32'd50, 32'd3);
    mdOp(2'b00, 32'd6, 32'd7);
    check("b2b_stall", stallCount, DIV_CYC);

    // Reset in the middle of a divide
    idle(MUL_CYC + 1);
    mdOp(2'b10, 32'd999, 32'd5);
    idle(9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", busy, 1'b0);
    mdOp(2'b00, 32'd3, 32'hFFFF_FFFE);
    check("post_rst_accept", stallCount, 0);
    readLo();
    check("post_rst_lo", lastHilo, 32'hFFFF_FFFA);
    readHi();
    check("post_rst_hi", lastHilo, 32'hFFFF_FFFF);

    // Randomized instruction stream, including simultaneous requests
    for (int n = 0; n < 150; n++) begin
      int k;
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2, 3, 4: mdOp(2'($urandom_range(0, 3)), randOperand(), randOperand());
        5: issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, $urandom, 32'd0);
        6: issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, $urandom, 32'd0);
        7: readHi();
        8: readLo();
        default: issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       randOperand(), randOperand());
      endcase
      idle($urandom_range(0, 2));
    end
    idle(DIV_CYC + 2);
    readHi();
    readLo();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
